// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_pkg
// Brief  : Shared bus widths, peripheral address map and arbiter state type.
// Rev    : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int unsigned c_BUS_AW = 32;
    localparam int unsigned c_BUS_DW = 32;

    localparam logic [31:0] c_BRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] c_TEXT_BASE  = 32'h0000_FF00;
    localparam logic [31:0] c_TEXT_LAST  = 32'h0000_FF7F;
    localparam logic [31:0] c_PSRAM_BASE = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    function automatic logic is_text_addr(input logic [31:0] addr);
        return (addr >= c_TEXT_BASE) && (addr <= c_TEXT_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin selector; search begins at i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_picker
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_valid
);

    int w_k;

    // Walking from the far end lets the requester nearest i_ptr overwrite last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_k   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = (int'(i_ptr) + i) % NUM_REQ;
            if (i_req[IW'(w_k)]) begin
                o_gnt            = '0;
                o_gnt[IW'(w_k)]  = 1'b1;
                o_idx            = IW'(w_k);
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin arbiter running one bus transaction at a time.
//          Define BUS_ARBITER_TIMEOUT_EN to build the wait-state timeout.
// Rev    : 1.0  initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = c_BUS_AW,
    parameter int DW      = c_BUS_DW,
    parameter int TIMEOUT = 255
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_we,
    input  logic [NUM_REQ*AW-1:0] i_addr,
    input  logic [NUM_REQ*DW-1:0] i_wr_data,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_ack,
    output logic [DW-1:0]         o_rd_data,
    output logic                  o_err,
    output logic                  o_bus_clk,
    output logic                  o_bus_we,
    output logic [AW-1:0]         o_bus_addr,
    output logic [DW-1:0]         o_bus_data,
    input  logic [DW-1:0]         i_bus_data,
    input  logic                  i_bus_data_ready
);

    localparam int IW = $clog2(NUM_REQ);

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit c_TIMEOUT_EN = 1'b1;
`else
    localparam bit c_TIMEOUT_EN = 1'b0;
`endif

    arb_state_e         r_state_q, w_state_d;
    logic [NUM_REQ-1:0] r_gnt_q, w_gnt_d;
    logic [NUM_REQ-1:0] r_ack_q, w_ack_d;
    logic               r_err_q, w_err_d;
    logic               r_bus_clk_q, w_bus_clk_d;
    logic               r_we_q, w_we_d;
    logic [AW-1:0]      r_addr_q, w_addr_d;
    logic [DW-1:0]      r_wdata_q, w_wdata_d;
    logic [DW-1:0]      r_rdata_q, w_rdata_d;
    logic [IW-1:0]      r_idx_q, w_idx_d;
    logic [IW-1:0]      r_ptr_q, w_ptr_d;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_valid;
    logic               w_timeout;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr_q),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    generate
        if (c_TIMEOUT_EN && (TIMEOUT > 0)) begin : g_timeout
            localparam int c_CNT_W = (TIMEOUT > 255) ? 16 : 8;
            logic [c_CNT_W-1:0] r_cnt_q;

            // Sits at zero outside WAIT, so it is cleared on every WAIT entry.
            always_ff @(posedge i_clk) begin
                if (i_rst || (r_state_q != WAIT)) begin
                    r_cnt_q <= '0;
                end else begin
                    r_cnt_q <= r_cnt_q + c_CNT_W'(1);
                end
            end

            assign w_timeout = (r_state_q == WAIT) && (r_cnt_q == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_d   = r_state_q;
        w_gnt_d     = r_gnt_q;
        w_ack_d     = '0;
        w_err_d     = 1'b0;
        w_bus_clk_d = 1'b0;
        w_we_d      = r_we_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_rdata_d   = r_rdata_q;
        w_idx_d     = r_idx_q;
        w_ptr_d     = r_ptr_q;

        case (r_state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_d   = ISSUE;
                    w_gnt_d     = w_pick_gnt;
                    w_idx_d     = w_pick_idx;
                    w_bus_clk_d = 1'b1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (w_pick_idx == IW'(k)) begin
                            w_we_d    = i_we[k];
                            w_addr_d  = i_addr[k*AW +: AW];
                            w_wdata_d = i_wr_data[k*DW +: DW];
                        end
                    end
                end
            end
            ISSUE: begin
                w_state_d = WAIT;
            end
            WAIT: begin
                // Ready has priority over a timeout landing on the same cycle.
                if (i_bus_data_ready || w_timeout) begin
                    w_state_d = IDLE;
                    w_ack_d   = r_gnt_q;
                    w_err_d   = !i_bus_data_ready;
                    w_rdata_d = i_bus_data_ready ? i_bus_data : '0;
                    w_gnt_d   = '0;
                    w_we_d    = 1'b0;
                    w_addr_d  = '0;
                    w_wdata_d = '0;
                    w_ptr_d   = (r_idx_q == IW'(NUM_REQ - 1)) ? '0 : r_idx_q + IW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= IDLE;
            r_gnt_q     <= '0;
            r_ack_q     <= '0;
            r_err_q     <= 1'b0;
            r_bus_clk_q <= 1'b0;
            r_we_q      <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_rdata_q   <= '0;
            r_idx_q     <= '0;
            r_ptr_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_gnt_q     <= w_gnt_d;
            r_ack_q     <= w_ack_d;
            r_err_q     <= w_err_d;
            r_bus_clk_q <= w_bus_clk_d;
            r_we_q      <= w_we_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_rdata_q   <= w_rdata_d;
            r_idx_q     <= w_idx_d;
            r_ptr_q     <= w_ptr_d;
        end
    end

    assign o_gnt      = r_gnt_q;
    assign o_ack      = r_ack_q;
    assign o_err      = r_err_q;
    assign o_rd_data  = r_rdata_q;
    assign o_bus_clk  = r_bus_clk_q;
    assign o_bus_we   = r_we_q;
    assign o_bus_addr = r_addr_q;
    assign o_bus_data = r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Directed and random stimulus against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N   = 3;
    localparam int TMO = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we, gnt, ack;
    logic [N*32-1:0] addr, wdata;
    logic [31:0]     rd_data, bus_addr, bus_wdata, bus_rdata;
    logic            err, bus_clk, bus_we, bus_rdy;

    bus_arbiter #(
        .NUM_REQ (N),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req            (req),
        .i_we             (we),
        .i_addr           (addr),
        .i_wr_data        (wdata),
        .o_gnt            (gnt),
        .o_ack            (ack),
        .o_rd_data        (rd_data),
        .o_err            (err),
        .o_bus_clk        (bus_clk),
        .o_bus_we         (bus_we),
        .o_bus_addr       (bus_addr),
        .o_bus_data       (bus_wdata),
        .i_bus_data       (bus_rdata),
        .i_bus_data_ready (bus_rdy)
    );

    always #5 clk = ~clk;

    // Values to drive on the next step
    logic         d_rst, d_rdy;
    logic [N-1:0] d_req, d_we;
    logic [31:0]  d_addr [N];
    logic [31:0]  d_wdata [N];
    logic [31:0]  d_bdata;

    // Model: owner -1 means bus free; waited -1 means strobe cycle
    int           m_owner, m_last, m_waited;
    logic [N-1:0] m_gnt, m_ack;
    logic         m_err, m_clk, m_we;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    bit           model_ok = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] ack_q [$];
    int           ack_t [$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic finish_txn(input bit ok);
        m_ack           = '0;
        m_ack[m_owner]  = 1'b1;
        m_err           = !ok;
        m_rdata         = ok ? d_bdata : 32'h0;
        m_last          = m_owner;
        m_owner         = -1;
        m_gnt           = '0;
        m_we            = 1'b0;
        m_addr          = '0;
        m_wdata         = '0;
    endtask

    task automatic model_step();
        int c;
        m_ack = '0;
        m_err = 1'b0;
        m_clk = 1'b0;
        if (d_rst) begin
            m_owner = -1; m_last = N - 1; m_waited = 0;
            m_gnt = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            model_ok = 1'b1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && d_req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_gnt = '0;
                m_gnt[m_owner] = 1'b1;
                m_clk    = 1'b1;
                m_we     = d_we[m_owner];
                m_addr   = d_addr[m_owner];
                m_wdata  = d_wdata[m_owner];
                m_waited = -1;
            end
        end else if (m_waited < 0) begin
            m_waited = 0;
        end else if (d_rdy) begin
            finish_txn(1'b1);
        end else begin
            m_waited++;
            if (TMO_EN && m_waited == TMO) finish_txn(1'b0);
        end
    endtask

    // One clock: check current outputs, drive next inputs, advance model
    task automatic step();
        @(negedge clk);
        if (model_ok) begin
            check_val("gnt", gnt, m_gnt);
            check_val("ack", ack, m_ack);
            check_val("err", err, m_err);
            check_val("bus_clk", bus_clk, m_clk);
            check_val("bus_we", bus_we, m_we);
            check_val("bus_addr", bus_addr, m_addr);
            check_val("bus_data", bus_wdata, m_wdata);
            check_val("rd_data", rd_data, m_rdata);
        end
        rst = d_rst; req = d_req; we = d_we; bus_rdy = d_rdy; bus_rdata = d_bdata;
        for (int k = 0; k < N; k++) begin
            addr[k*32 +: 32]  = d_addr[k];
            wdata[k*32 +: 32] = d_wdata[k];
        end
        model_step();
    endtask

    task automatic do_reset();
        d_rst = 1'b1; step(); step(); d_rst = 1'b0;
    endtask

    initial begin
        int seen;
        d_rst = 1'b1; d_rdy = 1'b0; d_req = '0; d_we = '0; d_bdata = '0;
        for (int k = 0; k < N; k++) begin d_addr[k] = '0; d_wdata[k] = '0; end
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; bus_rdy = 1'b0; bus_rdata = '0;

        // Reset state
        do_reset();
        check_val("rst_gnt", gnt, 0);
        check_val("rst_clk", bus_clk, 0);
        check_val("rst_rd", rd_data, 0);

        // Single write from master 0
        d_req = 3'b001; d_we = 3'b001; d_addr[0] = 32'h0000_1234; d_wdata[0] = 32'h55;
        step(); step();
        check_val("t1_strobe", bus_clk, 1);
        check_val("t1_addr", bus_addr, 32'h1234);
        check_val("t1_we", bus_we, 1);
        d_rdy = 1'b1; step();
        d_req = '0; d_rdy = 1'b0; step();
        check_val("t1_ack", ack, 3'b001);
        check_val("t1_err", err, 0);

        // Continuous requests from masters 0 and 1, immediate ready
        do_reset();
        d_rdy = 1'b1; d_we = '0;
        for (int i = 0; i < 19; i++) begin
            d_req = (i == 18) ? 3'b000 : 3'b011;
            step();
            if (ack != '0) begin ack_q.push_back(ack); ack_t.push_back(i); end
        end
        check_val("t2_count", ack_q.size(), 6);
        for (int i = 0; i < ack_q.size(); i++) begin
            check_val("t2_order", ack_q[i], (i % 2 == 0) ? 3'b001 : 3'b010);
            if (i > 0) check_val("t2_gap", ack_t[i] - ack_t[i-1], 3);
        end

        // Master 1 reads text area with four wait cycles
        d_rdy = 1'b0; d_req = 3'b010; d_we = '0; d_addr[1] = 32'h0000_FF10;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            d_rdy = (i == 4); d_bdata = 32'hA5;
            step();
            check_val("t3_addr", bus_addr, 32'h0000_FF10);
        end
        d_rdy = 1'b0; d_req = '0; step();
        check_val("t3_ack", ack, 3'b010);
        check_val("t3_rd", rd_data, 32'hA5);

        // Master 0 drops its request mid-transaction
        d_req = 3'b001; step();
        d_req = '0; step();
        d_rdy = 1'b1; step();
        d_req = 3'b010; step();
        check_val("t4_ack", ack, 3'b001);
        step();
        check_val("t4_gnt", gnt, 3'b010);
        d_req = '0; step(); step();

        // Reset while waiting
        d_req = 3'b100; d_rdy = 1'b0; step(); step();
        d_rst = 1'b1; step();
        d_rst = 1'b0; d_req = 3'b111; step();
        check_val("t5_ack", ack, 0);
        check_val("t5_gnt0", gnt, 0);
        check_val("t5_addr", bus_addr, 0);
        step();
        check_val("t5_gnt", gnt, 3'b001);
        d_req = '0; d_rdy = 1'b1; step(); step(); step();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Ready never arrives: timeout error then the other master
        seen = 0;
        d_req = 3'b011; d_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (err) begin seen++; check_val("t6_rd", rd_data, 0); end
        end
        check_val("t6_err_seen", seen, 1);
        d_req = '0; d_rdy = 1'b1; step(); step(); step();
`else
        seen = 0;
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            d_rst   = ($urandom_range(0, 63) == 0);
            d_req   = N'($urandom);
            d_we    = N'($urandom);
            d_rdy   = ($urandom_range(0, 2) != 0);
            d_bdata = $urandom;
            for (int k = 0; k < N; k++) begin d_addr[k] = $urandom; d_wdata[k] = $urandom; end
            step();
            seen += int'(err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single 32-bit memory/peripheral bus between NUM_REQ bus masters: CPU cores, plus a future DMA or video-fetch engine.
- Drives the existing bus signals: strobe, we, addr, wr_data, rd_data and rd_ready.
- Sits between the masters and the peripheral chip-select decode (BRAM, PSRAM, text area).
- Uses round-robin arbitration and runs exactly one transaction at a time.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- AW, 32, bus address width.
- DW, 32, bus data width.
- TIMEOUT, 255, wait-state limit in cycles; used only when the optional feature is compiled in.

Ports:
- i_clk  input  1  bus/system clock.
- i_rst  input  1  synchronous reset, active-high.
- i_req  input  NUM_REQ  per-master request; level; held until o_ack.
- i_we  input  NUM_REQ  per-master write enable.
- i_addr  input  NUM_REQ*AW  packed addresses; master k occupies bits [k*AW +: AW].
- i_wr_data  input  NUM_REQ*DW  packed write data.
- o_gnt  output  NUM_REQ  one-hot grant; held for the whole transaction.
- o_ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- o_rd_data  output  DW  read data, broadcast to all masters; valid during o_ack.
- o_err  output  1  pulses with o_ack on a timed-out transaction.
- o_bus_clk  output  1  bus strobe to peripherals.
- o_bus_we  output  1  bus write enable.
- o_bus_addr  output  AW  bus address.
- o_bus_data  output  DW  bus write data.
- i_bus_data  input  DW  muxed peripheral read data.
- i_bus_data_ready  input  1  muxed peripheral ready.

Behaviour:
- Reset (synchronous, i_rst=1 at the clock edge):
  - State goes to IDLE and the round-robin pointer to 0.
  - All outputs become 0.
  - Any in-flight transaction is abandoned and no ack is issued for it.
- IDLE:
  - If any i_req bit is set, select a winner by round-robin: search starts at (last_winner+1) mod NUM_REQ; after reset, master 0 has highest priority.
  - Latch the winner's we, addr and wr_data into internal registers.
  - Assert o_gnt[winner] and go to ISSUE.
  - No request: stay in IDLE with all outputs 0.
- ISSUE (exactly 1 cycle):
  - o_bus_clk=1, with o_bus_we/addr/data taken from the latched values.
  - Go to WAIT.
- WAIT:
  - o_bus_clk=0; o_bus_we/addr/data stay stable.
  - On i_bus_data_ready=1: capture i_bus_data into o_rd_data, pulse o_ack[winner] for 1 cycle, update last_winner, then go to IDLE. o_gnt drops in the same cycle o_ack rises.
  - Writes also complete on i_bus_data_ready. For writes, o_rd_data is still updated, and its value is don't-care to the master.
- Latency and throughput:
  - Minimum request-to-ack is 3 cycles: IDLE, ISSUE, then WAIT with ready already high.
  - Back-to-back transactions always have one IDLE cycle between them.
- i_bus_data_ready high during IDLE or ISSUE is ignored.
- A master dropping i_req mid-transaction does not cancel it; the transaction completes and o_ack is still issued.
- A master holding i_req after its own ack is treated as a new request, subject to round-robin.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,NUM_REQ-1,0.
- o_rd_data holds its last value between transactions. It is reset to 0.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no ready: o_ack[winner]=1, o_err=1, o_rd_data=0, and the pointer advances as normal.
  - If ready arrives on the same cycle the counter reaches TIMEOUT, ready wins and o_err=0.
- Not defined:
  - No counter is built and o_err is tied 0.
  - WAIT holds indefinitely until ready.

Decomposition:
- Shared package bus_pkg holds:
  - AW/DW defaults and peripheral base-address constants (BRAM 0x0000xxxx, text 0x0000FF00..FF7F, PSRAM 0x40xxxxxx).
  - An arbiter state enum: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
- One natural sub-module, rr_picker: combinational round-robin one-hot selector taking the request vector and pointer, producing a one-hot grant and the winner index.

Test Plan:
1. Reset, then i_req=2'b01, write addr 0x0000_1234, data 0x55, ready 1 cycle after strobe -> o_bus_clk pulses 1 cycle with addr 0x1234 and we=1; o_ack=2'b01 at cycle 3; o_err=0.
2. Both masters request continuously for 6 transactions, ready immediate -> grant order 0,1,0,1,0,1; one IDLE cycle between acks.
3. Master 1 reads 0x0000_FF10 and the peripheral returns 0xA5 after 4 wait cycles -> o_rd_data=0x000000A5 with o_ack=2'b10 on the ready cycle; o_bus_addr stable throughout.
4. Master 0 drops i_req during WAIT -> transaction still completes and o_ack[0] pulses; the next grant goes to master 1 if it is requesting.
5. i_rst asserted during WAIT -> the next cycle has all outputs 0 and no ack; the first grant after reset goes to master 0.
6. (BUS_ARBITER_TIMEOUT_EN, TIMEOUT=8) ready never asserted -> o_ack and o_err pulse together after 8 WAIT cycles with o_rd_data=0; the other master is granted next.
